// File: rtl/lif_neuron.sv
//------------------------------------------------------------------------------
// lif_neuron
//
// Single leaky integrate-and-fire neuron with one binary synaptic input.
// Every clock the membrane potential gains WEIGHT when input_spike is high and
// loses LEAK unconditionally. When the candidate potential reaches THRESHOLD
// the neuron emits a one-cycle spike and the potential restarts from zero.
// Any charge above the threshold is discarded.
//
// Ports:
//   clk          in   system clock; all state changes on the rising edge
//   rst_n        in   synchronous, active-low reset
//   input_spike  in   presynaptic spike, level-sampled every rising edge
//   spike_out    out  registered postsynaptic spike, one cycle per fire
//
// Optional build macro:
//   LIF_REFRACTORY_EN  when defined, a fire starts a dead time of
//                      REFRACTORY_CYCLES cycles. During the dead time the
//                      input is ignored, the potential stays at 0 and the
//                      neuron cannot fire. Without the macro, integration
//                      resumes on the cycle right after a fire.
//------------------------------------------------------------------------------
module lif_neuron #(
   parameter int unsigned WEIGHT            = 10,
   parameter int unsigned THRESHOLD         = 15,
   parameter int unsigned LEAK              = 1,
   parameter int unsigned POTENTIAL_WIDTH   = 8,
   parameter int unsigned REFRACTORY_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic input_spike,
   output logic spike_out
);

   // The candidate carries two extra bits: one for the sign, which lets us
   // see an underflow after the leak, and one for headroom, which lets us
   // see an overflow past the potential register range.
   localparam int unsigned CW = POTENTIAL_WIDTH + 2;

   localparam logic signed [CW-1:0] ZERO_S   = '0;
   localparam logic signed [CW-1:0] WEIGHT_S = CW'(WEIGHT);
   localparam logic signed [CW-1:0] LEAK_S   = CW'(LEAK);
   localparam logic signed [CW-1:0] THRESH_S = CW'(THRESHOLD);
   localparam logic signed [CW-1:0] MAX_S    = {2'b00, {POTENTIAL_WIDTH{1'b1}}};

   logic [POTENTIAL_WIDTH-1:0] potential_q, potential_d;
   logic                       spike_q, spike_d;
   logic signed [CW-1:0]       cand;
   logic                       integrate_en;
   logic                       fire;

`ifdef LIF_REFRACTORY_EN
   localparam int unsigned RW = (REFRACTORY_CYCLES > 0) ? $clog2(REFRACTORY_CYCLES + 1) : 1;
   localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACTORY_CYCLES);

   logic [RW-1:0] refr_q, refr_d;

   // A nonzero counter means the neuron is still in its dead time.
   assign integrate_en = (refr_q == '0);

   always_comb begin
      refr_d = refr_q;
      if (refr_q != '0) begin
         refr_d = refr_q - 1'b1;
      end else if (fire) begin
         refr_d = REFR_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         refr_q <= '0;
      end else begin
         refr_q <= refr_d;
      end
   end
`else
   assign integrate_en = 1'b1;

   // REFRACTORY_CYCLES has no effect in this build. It is kept so that both
   // builds share one parameter list, and it is referenced here only so that
   // it counts as used.
   if (REFRACTORY_CYCLES > 0) begin : g_refractory_param_unused
   end
`endif

   // All operands are signed and CW bits wide, so the sum cannot wrap.
   assign cand = $signed({2'b00, potential_q})
               + (input_spike ? WEIGHT_S : ZERO_S)
               - LEAK_S;

   assign fire = integrate_en && (cand >= THRESH_S);

   always_comb begin
      potential_d = potential_q;
      spike_d     = 1'b0;
      if (!integrate_en) begin
         potential_d = '0;
      end else if (fire) begin
         spike_d     = 1'b1;
         potential_d = '0;
      end else if (cand < ZERO_S) begin
         potential_d = '0;
      end else if (cand > MAX_S) begin
         // This branch is only reachable when THRESHOLD is set above the
         // register range. It is kept so the potential never wraps.
         potential_d = '1;
      end else begin
         potential_d = cand[POTENTIAL_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         potential_q <= '0;
         spike_q     <= 1'b0;
      end else begin
         potential_q <= potential_d;
         spike_q     <= spike_d;
      end
   end

   assign spike_out = spike_q;

endmodule

// File: tb/tb_lif_neuron.sv
//------------------------------------------------------------------------------
// tb_lif_neuron
//
// Drives two neurons from the same stimulus:
//   dut_a  default parameters
//   dut_b  WEIGHT=200, LEAK=0, THRESHOLD=255, POTENTIAL_WIDTH=8
// Each neuron is followed by a reference model. The model is written with
// plain integer arithmetic taken straight from the neuron's rules.
//------------------------------------------------------------------------------
module tb_lif_neuron;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic input_spike = 1'b0;
   logic spike_out_a, spike_out_b;

   always #5 clk = ~clk;

`ifdef LIF_REFRACTORY_EN
   localparam bit REFR_EN = 1'b1;
`else
   localparam bit REFR_EN = 1'b0;
`endif
   localparam int REFR_CYCLES = 2;
   localparam int HOLD_PERIOD = REFR_EN ? 4 : 2;

   lif_neuron dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_spike (input_spike),
      .spike_out   (spike_out_a)
   );

   lif_neuron #(
      .WEIGHT          (200),
      .THRESHOLD       (255),
      .LEAK            (0),
      .POTENTIAL_WIDTH (8)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_spike (input_spike),
      .spike_out   (spike_out_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int pot_a = 0, refr_a = 0;
   bit spk_a = 1'b0;
   int pot_b = 0, refr_b = 0;
   bit spk_b = 1'b0;

   function automatic void model_step(input int weight, input int thr, input int leak,
                                      input int width, input bit s,
                                      inout int pot, inout int refr, output bit fire);
      int cand;
      int maxv;
      maxv = (1 << width) - 1;
      cand = pot + (s ? weight : 0) - leak;
      fire = 1'b0;
      if (REFR_EN && refr > 0) begin
         refr = refr - 1;
         pot  = 0;
      end else if (cand >= thr) begin
         fire = 1'b1;
         pot  = 0;
         if (REFR_EN) refr = REFR_CYCLES;
      end else if (cand < 0) begin
         pot = 0;
      end else if (cand > maxv) begin
         pot = maxv;
      end else begin
         pot = cand;
      end
   endfunction

   // driver: apply one cycle of stimulus, then advance both models
   task automatic tick(input bit s, input bit rst);
      @(negedge clk);
      input_spike = s;
      rst_n       = ~rst;
      @(posedge clk);
      #1;
      if (rst) begin
         pot_a = 0; refr_a = 0; spk_a = 1'b0;
         pot_b = 0; refr_b = 0; spk_b = 1'b0;
      end else begin
         model_step(10, 15, 1, 8, s, pot_a, refr_a, spk_a);
         model_step(200, 255, 0, 8, s, pot_b, refr_b, spk_b);
      end
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      n_checks++;
      if (spike_out_a !== 1'b0 || dut_a.potential_q !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_a: spike_out=%b potential=%0d, required 0/0", spike_out_a, dut_a.potential_q);
      end
      n_checks++;
      if (spike_out_b !== 1'b0 || dut_b.potential_q !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_b: spike_out=%b potential=%0d, required 0/0", spike_out_b, dut_b.potential_q);
      end
   endtask

   task automatic test_worked_example();
      bit seq[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int exp_pot[6] = '{9, 8, 7, 0, 0, 0};
      bit exp_spk[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tick(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick(seq[i], 1'b0);
         n_checks++;
         if (spike_out_a !== exp_spk[i] || int'(dut_a.potential_q) != exp_pot[i]) begin
            n_fail++;
            $display("FAIL worked_example[%0d]: spike_out=%b potential=%0d, required %b/%0d",
                     i, spike_out_a, dut_a.potential_q, exp_spk[i], exp_pot[i]);
         end
      end
   endtask

   task automatic test_isolated_spikes();
      int pulses = 0;
      tick(1'b0, 1'b1);
      for (int r = 0; r < 3; r++) begin
         tick(1'b1, 1'b0);
         n_checks++;
         if (dut_a.potential_q !== 8'd9) begin
            n_fail++;
            $display("FAIL isolated_peak[%0d]: potential=%0d, required 9", r, dut_a.potential_q);
         end
         for (int i = 0; i < 13; i++) begin
            tick(1'b0, 1'b0);
            if (spike_out_a === 1'b1) pulses++;
            n_checks++;
            if (int'(dut_a.potential_q) != pot_a) begin
               n_fail++;
               $display("FAIL isolated_decay[%0d,%0d]: potential=%0d, required %0d",
                        r, i, dut_a.potential_q, pot_a);
            end
         end
         n_checks++;
         if (dut_a.potential_q !== 8'd0) begin
            n_fail++;
            $display("FAIL isolated_gap_end[%0d]: potential=%0d, required 0", r, dut_a.potential_q);
         end
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL isolated_pulses: got %0d pulses, required 0", pulses);
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      n_checks++;
      if (spike_out_a !== 1'b0 || dut_a.potential_q !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid: spike_out=%b potential=%0d, required 0/0", spike_out_a, dut_a.potential_q);
      end
      tick(1'b1, 1'b0);
      n_checks++;
      if (dut_a.potential_q !== 8'd9 || spike_out_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_residue: spike_out=%b potential=%0d, required 0/9", spike_out_a, dut_a.potential_q);
      end
   endtask

   task automatic test_pattern();
      bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int pulses = 0;
      bit prev = 1'b0;
      tick(1'b0, 1'b1);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 7; i++) begin
            tick(pat[i], 1'b0);
            if (spike_out_a === 1'b1) pulses++;
            n_checks++;
            if (spike_out_a !== spk_a || (prev && spike_out_a)) begin
               n_fail++;
               $display("FAIL pattern[%0d,%0d]: spike_out=%b (prev %b), required %b",
                        r, i, spike_out_a, prev, spk_a);
            end
            prev = spike_out_a;
         end
      end
      n_checks++;
      if (pulses != 3) begin
         n_fail++;
         $display("FAIL pattern_pulses: got %0d pulses, required 3", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int pulse_cyc[$];
      tick(1'b0, 1'b1);
      for (int c = 1; c <= 17; c++) begin
         tick(1'b1, 1'b0);
         if (c == 1) begin
            n_checks++;
            if (dut_a.potential_q !== 8'd9) begin
               n_fail++;
               $display("FAIL hold_first: potential=%0d, required 9", dut_a.potential_q);
            end
         end
         if (spike_out_a === 1'b1) pulse_cyc.push_back(c);
      end
      n_checks++;
      if (pulse_cyc.size() < 3 || pulse_cyc[0] != 2) begin
         n_fail++;
         $display("FAIL hold_first_fire: %0d pulses, first at %0d, required first at 2",
                  pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1);
      end
      for (int i = 1; i < pulse_cyc.size(); i++) begin
         n_checks++;
         if (pulse_cyc[i] - pulse_cyc[i-1] != HOLD_PERIOD) begin
            n_fail++;
            $display("FAIL hold_period[%0d]: got %0d cycles, required %0d",
                     i, pulse_cyc[i] - pulse_cyc[i-1], HOLD_PERIOD);
         end
      end
   endtask

   task automatic test_wide();
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      n_checks++;
      if (dut_b.potential_q !== 8'd200 || spike_out_b !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_first: spike_out=%b potential=%0d, required 0/200", spike_out_b, dut_b.potential_q);
      end
      tick(1'b1, 1'b0);
      n_checks++;
      if (dut_b.potential_q !== 8'd0 || spike_out_b !== 1'b1) begin
         n_fail++;
         $display("FAIL wide_fire: spike_out=%b potential=%0d, required 1/0", spike_out_b, dut_b.potential_q);
      end
      tick(1'b0, 1'b0);
      n_checks++;
      if (dut_b.potential_q !== 8'd0 || spike_out_b !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_after: spike_out=%b potential=%0d, required 0/0", spike_out_b, dut_b.potential_q);
      end
   endtask

   task automatic test_random();
      bit s, r;
      tick(1'b0, 1'b1);
      for (int c = 0; c < 400; c++) begin
         s = ($urandom_range(0, 99) < 45);
         r = ($urandom_range(0, 99) < 2);
         tick(s, r);
         n_checks++;
         if (spike_out_a !== spk_a || int'(dut_a.potential_q) != pot_a) begin
            n_fail++;
            $display("FAIL random_a[%0d]: spike_out=%b potential=%0d, required %b/%0d",
                     c, spike_out_a, dut_a.potential_q, spk_a, pot_a);
         end
         n_checks++;
         if (spike_out_b !== spk_b || int'(dut_b.potential_q) != pot_b) begin
            n_fail++;
            $display("FAIL random_b[%0d]: spike_out=%b potential=%0d, required %b/%0d",
                     c, spike_out_b, dut_b.potential_q, spk_b, pot_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_worked_example();
      test_isolated_spikes();
      test_reset_mid();
      test_pattern();
      test_back_to_back();
      test_wide();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
